uart_tx_serializer: RTL and testbench

//   Transmit end of the team's serial link: accepts one parallel word per

---
 rtl/uart_tx_serializer_if.sv | 21 ++
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Producer-side handshake for the UART transmit serializer: one word moves per
// cycle in which valid_in and ready_out are both high.
interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes a word over a valid/ready handshake and sends
// start bit, data LSB first, optional even parity and stop bit on tx.
module uart_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   shift, shift_nxt;
  logic                par, par_nxt;
  logic                tx_nxt, busy_nxt, done_nxt;
  logic                baud_end;

  assign baud_end      = (baud == BAUD_LAST);
  assign bus.ready_out = (state == IDLE);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;

    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          state_nxt = START;
          shift_nxt = bus.data_in;
          par_nxt   = ^bus.data_in;
          bit_nxt   = '0;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          state_nxt = STOP;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          done_nxt  = 1'b1;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // Line level and busy are decoded from the state being entered so they
    // register in the same edge as the state itself.
    case (state_nxt)
      IDLE:    begin tx_nxt = 1'b1;         busy_nxt = 1'b0; end
      START:   begin tx_nxt = 1'b0;         busy_nxt = 1'b1; end
      DATA:    begin tx_nxt = shift_nxt[0]; busy_nxt = 1'b1; end
      PARITY:  begin tx_nxt = par_nxt;      busy_nxt = 1'b1; end
      STOP:    begin tx_nxt = 1'b1;         busy_nxt = 1'b1; end
      default: begin tx_nxt = 1'b1;         busy_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a 4-clock parity build and a 1-clock no-parity
// build, expected line bits queued at send time and popped while the frame runs.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic reset;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  int vectors    = 0;
  int miscompares = 0;
  logic exp_q[$];

  uart_tx_serializer_if #(.DATA_W(8)) bus0 ();
  uart_tx_serializer_if #(.DATA_W(8)) bus1 ();

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave),
    .tx    (tx0),
    .busy  (busy0),
    .done  (done0)
  );

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input bit par_en);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par_en) exp_q.push_back(^d);
    exp_q.push_back(1'b1);
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    int k;
    k = 0;
    while (((sel == 0) ? bus0.ready_out : bus1.ready_out) !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", (sel == 0) ? bus0.ready_out : bus1.ready_out, 1'b1);
    if (sel == 0) begin bus0.data_in = d; bus0.valid_in = 1'b1; end
    else          begin bus1.data_in = d; bus1.valid_in = 1'b1; end
    tick();
    if (sel == 0) bus0.valid_in = 1'b0;
    else          bus1.valid_in = 1'b0;
  endtask

  // Called one sample after the accept edge; leaves off in the done cycle.
  task automatic check_frame(input int sel, input int nbits, input int cpb,
                             input int glitch, input string tag);
    logic e;
    int cyc;
    for (int b = 0; b < nbits; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < cpb; c++) begin
        cyc = b * cpb + c;
        if (cyc == glitch) begin bus0.data_in = 8'hFF; bus0.valid_in = 1'b1; end
        if (cyc == glitch + 2) bus0.valid_in = 1'b0;
        chk({tag, "_tx"},    (sel == 0) ? tx0 : tx1, e);
        chk({tag, "_busy"},  (sel == 0) ? busy0 : busy1, 1'b1);
        chk({tag, "_ready"}, (sel == 0) ? bus0.ready_out : bus1.ready_out, 1'b0);
        chk({tag, "_done"},  (sel == 0) ? done0 : done1, 1'b0);
        tick();
      end
    end
    chk({tag, "_done_pulse"}, (sel == 0) ? done0 : done1, 1'b1);
    chk({tag, "_end_ready"},  (sel == 0) ? bus0.ready_out : bus1.ready_out, 1'b1);
    chk({tag, "_end_busy"},   (sel == 0) ? busy0 : busy1, 1'b0);
    chk({tag, "_end_tx"},     (sel == 0) ? tx0 : tx1, 1'b1);
  endtask

  initial begin
    reset         = 1'b1;
    bus0.data_in  = 8'h00;
    bus0.valid_in = 1'b0;
    bus1.data_in  = 8'h00;
    bus1.valid_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      chk("idle_tx", tx0, 1'b1);
      chk("idle_ready", bus0.ready_out, 1'b1);
      chk("idle_busy", busy0, 1'b0);
      chk("idle_done", done0, 1'b0);
      tick();
    end

    // Single frame 0xA5
    push_frame(8'hA5, 1'b1);
    send(0, 8'hA5);
    check_frame(0, 11, 4, -10, "a5");
    tick();
    chk("a5_done_one_cycle", done0, 1'b0);

    // Back-to-back 0x07 then 0x80 with valid held
    push_frame(8'h07, 1'b1);
    push_frame(8'h80, 1'b1);
    bus0.data_in  = 8'h07;
    bus0.valid_in = 1'b1;
    tick();
    bus0.data_in = 8'h80;
    check_frame(0, 11, 4, -10, "b2b_07");
    tick();
    bus0.valid_in = 1'b0;
    check_frame(0, 11, 4, -10, "b2b_80");
    tick();
    chk("b2b_done_clear", done0, 1'b0);

    // valid pulse with 0xFF mid-frame is ignored
    push_frame(8'h5A, 1'b1);
    send(0, 8'h5A);
    check_frame(0, 11, 4, 13, "ign");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_no_frame_tx", tx0, 1'b1);
      chk("ign_no_frame_busy", busy0, 1'b0);
      chk("ign_no_frame_done", done0, 1'b0);
    end

    // Async reset during data bit 3
    send(0, 8'h00);
    for (int i = 0; i < 17; i++) tick();
    chk("rst_pre_tx", tx0, 1'b0);
    chk("rst_pre_busy", busy0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_tx", tx0, 1'b1);
    chk("rst_async_busy", busy0, 1'b0);
    chk("rst_async_ready", bus0.ready_out, 1'b1);
    chk("rst_async_done", done0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("rst_post_done", done0, 1'b0);
      chk("rst_post_tx", tx0, 1'b1);
      tick();
    end
    push_frame(8'h3C, 1'b1);
    send(0, 8'h3C);
    check_frame(0, 11, 4, -10, "3c");
    tick();

    // No-parity, one clock per bit build
    push_frame(8'h01, 1'b0);
    send(1, 8'h01);
    check_frame(1, 10, 1, -10, "np");
    tick();
    chk("np_done_one_cycle", done1, 1'b0);
    chk("np_idle_tx", tx1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
